// File: rtl/ldm_stm_seq_pkg.sv
// ldm_stm_seq_pkg: FSM encodings, addressing modes and helpers shared by the LDM/STM sequencer.
package ldm_stm_seq_pkg;

    localparam logic [3:0] REG_PC = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_WB   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Encoded as {pre, up}
    typedef enum logic [1:0] {
        AM_DA = 2'b00,
        AM_IA = 2'b01,
        AM_DB = 2'b10,
        AM_IB = 2'b11
    } amode_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/ldm_stm_seq_lsb_pick.sv
// ldm_stm_seq_lsb_pick: combinational lowest-set-bit encoder for a 16-bit register list.
module ldm_stm_seq_lsb_pick (
    input  logic [15:0] vec_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 15; i >= 0; i--) if (vec_i[i]) idx_o = 4'(i);
    end

    assign valid_o = |vec_i;

endmodule

// File: rtl/ldm_stm_seq.sv
// ldm_stm_seq: multi-cycle LDM/STM sequencer walking the register list one register per cycle.
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic            is_load_i,
    input  logic            pre_i,
    input  logic            up_i,
    input  logic            wback_i,
    input  logic [3:0]      rn_i,
    input  logic [DW-1:0]   base_i,
    input  logic [NREG-1:0] reglist_i,
    output logic [3:0]      rf_ra_o,
    input  logic [DW-1:0]   rf_rd_i,
    output logic            rf_we_o,
    output logic [3:0]      rf_wa_o,
    output logic [DW-1:0]   rf_wd_o,
    output logic            pc_we_o,
    output logic [DW-1:0]   pc_wd_o,
    output logic [DW-1:0]   mem_addr_o,
    output logic            mem_we_o,
    output logic [DW-1:0]   mem_wd_o,
    input  logic [DW-1:0]   mem_rd_i,
    output logic            busy_o,
    output logic            done_o
);

    state_t          state_q, state_d;
    logic            load_q, wb_q;
    logic [3:0]      rn_q;
    logic [NREG-1:0] list_q, rest;
    logic [DW-1:0]   addr_q, fbase_q, n4, start_addr;
    logic [3:0]      k;
    logic            kv, xfer, ld, st, ldpc, ldr, wbs;
    amode_t          am;

    ldm_stm_seq_lsb_pick u_pick (
        .vec_i   (list_q),
        .idx_o   (k),
        .valid_o (kv)
    );

    assign rest = list_q & (list_q - NREG'(1));
    assign n4   = DW'({popcount16(reglist_i), 2'b00});
    assign am   = amode_t'({pre_i, up_i});
    assign start_addr = am == AM_IA ? base_i :
                        am == AM_IB ? base_i + DW'(4) :
                        am == AM_DA ? base_i - n4 + DW'(4) : base_i - n4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // A loaded base register overrides writeback, so writeback is dropped at latch time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_q  <= 1'b0;
            wb_q    <= 1'b0;
            rn_q    <= '0;
            list_q  <= '0;
            addr_q  <= '0;
            fbase_q <= '0;
        end else if (state_q == S_IDLE && start_i) begin
            load_q  <= is_load_i;
            wb_q    <= wback_i && rn_i != REG_PC && !(is_load_i && reglist_i[rn_i]);
            rn_q    <= rn_i;
            list_q  <= reglist_i;
            addr_q  <= start_addr;
            fbase_q <= up_i ? base_i + n4 : base_i - n4;
        end else if (xfer) begin
            list_q  <= rest;
            addr_q  <= addr_q + DW'(4);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = reglist_i == '0 ? S_DONE : S_XFER;
            S_XFER:  if (rest == '0) state_d = wb_q ? S_WB : S_DONE;
            S_WB:    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        xfer       = state_q == S_XFER && kv;
        ld         = xfer && load_q;
        st         = xfer && !load_q;
        wbs        = state_q == S_WB;
        ldpc       = ld && k == REG_PC;
        ldr        = ld && k != REG_PC;
        rf_ra_o    = st ? k : 4'd0;
        mem_addr_o = xfer ? addr_q : '0;
        mem_we_o   = st;
        mem_wd_o   = st ? rf_rd_i : '0;
        rf_we_o    = ldr || wbs;
        rf_wa_o    = ldr ? k : wbs ? rn_q : 4'd0;
        rf_wd_o    = ldr ? mem_rd_i : wbs ? fbase_q : '0;
        pc_we_o    = ldpc;
        pc_wd_o    = ldpc ? mem_rd_i : '0;
        busy_o     = state_q != S_IDLE;
        done_o     = state_q == S_DONE;
    end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// tb_ldm_stm_seq: scoreboard bench for the LDM/STM sequencer with regfile and memory models.
module tb_ldm_stm_seq;

    typedef struct {
        logic        mem_we;
        logic        rf_we;
        logic        pc_we;
        logic        chk_addr;
        logic [31:0] addr;
        logic [3:0]  rg;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, is_load = 1'b0, pre = 1'b0, up = 1'b0, wback = 1'b0;
    logic [3:0]  rn = '0;
    logic [31:0] base = '0;
    logic [15:0] reglist = '0;
    logic [3:0]  rf_ra, rf_wa;
    logic [31:0] rf_rd, rf_wd, pc_wd, mem_addr, mem_wd, mem_rd;
    logic        rf_we, pc_we, mem_we, busy, done;

    logic [31:0] regs [0:15];
    logic [31:0] mem  [0:1023];
    ev_t         sb [$];
    int          compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    assign rf_rd  = regs[rf_ra];
    assign mem_rd = mem[mem_addr[11:2]];

    ldm_stm_seq dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .is_load_i(is_load), .pre_i(pre),
        .up_i(up), .wback_i(wback), .rn_i(rn), .base_i(base), .reglist_i(reglist),
        .rf_ra_o(rf_ra), .rf_rd_i(rf_rd), .rf_we_o(rf_we), .rf_wa_o(rf_wa), .rf_wd_o(rf_wd),
        .pc_we_o(pc_we), .pc_wd_o(pc_wd), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_wd_o(mem_wd), .mem_rd_i(mem_rd), .busy_o(busy), .done_o(done)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wd;
        if (rf_we) regs[rf_wa] <= rf_wd;
    end

    // Every strobe cycle must match the next queued expectation
    always @(negedge clk) begin
        if (rst_n && (mem_we || rf_we || pc_we)) begin
            ev_t e;
            logic [31:0] oaddr, odata;
            logic [3:0]  org;
            oaddr = mem_addr;
            org   = mem_we ? rf_ra : rf_we ? rf_wa : 4'hF;
            odata = mem_we ? mem_wd : rf_we ? rf_wd : pc_wd;
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_strobe: got we=%b%b%b addr=%h reg=%0d data=%h, wanted none",
                         mem_we, rf_we, pc_we, oaddr, org, odata);
            end else begin
                e = sb.pop_front();
                if ({mem_we, rf_we, pc_we, org, odata} !== {e.mem_we, e.rf_we, e.pc_we, e.rg, e.data} ||
                    (e.chk_addr && oaddr !== e.addr)) begin
                    mismatched++;
                    $display("FAIL strobe: got we=%b%b%b addr=%h reg=%0d data=%h, wanted we=%b%b%b addr=%h reg=%0d data=%h",
                             mem_we, rf_we, pc_we, oaddr, org, odata,
                             e.mem_we, e.rf_we, e.pc_we, e.addr, e.rg, e.data);
                end
            end
            if (rf_we && rf_wa == 4'd15) begin
                mismatched++;
                $display("FAIL rf_wa15: got rf_wa=15, wanted never 15");
            end
        end
    end

    function automatic ev_t ev(input logic m, input logic r, input logic p, input logic ca,
                               input logic [31:0] a, input logic [3:0] g, input logic [31:0] d);
        ev_t e;
        e.mem_we = m; e.rf_we = r; e.pc_we = p; e.chk_addr = ca; e.addr = a; e.rg = g; e.data = d;
        return e;
    endfunction

    task automatic kick(input logic ld, input logic p, input logic u, input logic w,
                        input logic [3:0] r, input logic [31:0] b, input logic [15:0] l);
        @(negedge clk);
        is_load = ld; pre = p; up = u; wback = w; rn = r; base = b; reglist = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
    endtask

    task automatic test_reset();
        #1;
        compared++;
        if ({rf_we, pc_we, mem_we, done, busy, rf_ra, rf_wa, mem_addr, mem_wd, rf_wd, pc_wd} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got we=%b%b%b done=%b busy=%b ra=%0d wa=%0d addr=%h, wanted all 0",
                     rf_we, pc_we, mem_we, done, busy, rf_ra, rf_wa, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stm_ia();
        int lat;
        regs[1] = 32'h11; regs[2] = 32'h22; regs[4] = 32'h44;
        sb.push_back(ev(1, 0, 0, 1, 32'h100, 4'd1, 32'h11));
        sb.push_back(ev(1, 0, 0, 1, 32'h104, 4'd2, 32'h22));
        sb.push_back(ev(1, 0, 0, 1, 32'h108, 4'd4, 32'h44));
        kick(0, 0, 1, 0, 4'd13, 32'h100, 16'h0016);
        #1;
        compared++;
        if (busy !== 1'b1) begin mismatched++; $display("FAIL stm_ia_busy: got %b, wanted 1", busy); end
        wait_done(lat);
        compared++;
        if (lat != 4) begin mismatched++; $display("FAIL stm_ia_latency: got %0d, wanted 4", lat); end
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL stm_ia_pending: got %0d left, wanted 0", sb.size()); sb.delete(); end
        @(negedge clk);
        compared++;
        if ({mem[32'h104 >> 2], busy, done} !== {32'h22, 2'b00}) begin
            mismatched++;
            $display("FAIL stm_ia_mem: got mem104=%h busy=%b done=%b, wanted 22/0/0", mem[32'h104 >> 2], busy, done);
        end
    endtask

    task automatic test_ldm_db_wb();
        int lat;
        for (int i = 0; i < 4; i++) begin
            mem[(32'h1F0 >> 2) + i] = 32'hA000 + 32'(i);
            sb.push_back(ev(0, 1, 0, 1, 32'h1F0 + 32'(4 * i), 4'(4 + i), 32'hA000 + 32'(i)));
        end
        sb.push_back(ev(0, 1, 0, 0, 32'h0, 4'd13, 32'h1F0));
        kick(1, 1, 0, 1, 4'd13, 32'h200, 16'h00F0);
        wait_done(lat);
        compared++;
        if (lat != 6) begin mismatched++; $display("FAIL ldm_db_latency: got %0d, wanted 6", lat); end
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL ldm_db_pending: got %0d left, wanted 0", sb.size()); sb.delete(); end
        compared++;
        if ({regs[7], regs[13]} !== {32'hA003, 32'h1F0}) begin
            mismatched++;
            $display("FAIL ldm_db_regs: got R7=%h R13=%h, wanted a003/1f0", regs[7], regs[13]);
        end
    endtask

    task automatic test_ldm_pc();
        int lat;
        mem[32'h40 >> 2] = 32'hA; mem[32'h44 >> 2] = 32'h80;
        sb.push_back(ev(0, 1, 0, 1, 32'h40, 4'd0, 32'hA));
        sb.push_back(ev(0, 0, 1, 1, 32'h44, 4'hF, 32'h80));
        kick(1, 0, 1, 0, 4'd3, 32'h40, 16'h8001);
        wait_done(lat);
        compared++;
        if (lat != 3) begin mismatched++; $display("FAIL ldm_pc_latency: got %0d, wanted 3", lat); end
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL ldm_pc_pending: got %0d left, wanted 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_ldm_rn_in_list();
        int lat;
        mem[32'h500 >> 2] = 32'hDEAD;
        sb.push_back(ev(0, 1, 0, 1, 32'h500, 4'd2, 32'hDEAD));
        kick(1, 0, 1, 1, 4'd2, 32'h500, 16'h0004);
        wait_done(lat);
        compared++;
        if (lat != 2) begin mismatched++; $display("FAIL ldm_rn_latency: got %0d, wanted 2", lat); end
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL ldm_rn_pending: got %0d left, wanted 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_stm_da_rn_in_list();
        int lat;
        regs[1] = 32'h1111; regs[4] = 32'h400;
        sb.push_back(ev(1, 0, 0, 1, 32'h3FC, 4'd1, 32'h1111));
        sb.push_back(ev(1, 0, 0, 1, 32'h400, 4'd4, 32'h400));
        sb.push_back(ev(0, 1, 0, 0, 32'h0, 4'd4, 32'h3F8));
        kick(0, 0, 0, 1, 4'd4, 32'h400, 16'h0012);
        wait_done(lat);
        compared++;
        if (lat != 4) begin mismatched++; $display("FAIL stm_da_latency: got %0d, wanted 4", lat); end
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL stm_da_pending: got %0d left, wanted 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_empty();
        int lat;
        kick(1, 0, 1, 1, 4'd5, 32'h700, 16'h0000);
        wait_done(lat);
        compared++;
        if (lat != 1) begin mismatched++; $display("FAIL empty_latency: got %0d, wanted 1", lat); end
    endtask

    task automatic test_back_to_back();
        int lat;
        mem[32'h604 >> 2] = 32'h6604; mem[32'h608 >> 2] = 32'h6608;
        regs[9] = 32'h99;
        sb.push_back(ev(0, 1, 0, 1, 32'h604, 4'd0, 32'h6604));
        sb.push_back(ev(0, 1, 0, 1, 32'h608, 4'd1, 32'h6608));
        sb.push_back(ev(1, 0, 0, 1, 32'h800, 4'd9, 32'h99));
        kick(1, 1, 1, 0, 4'd8, 32'h600, 16'h0003);
        wait_done(lat);
        compared++;
        if (lat != 3) begin mismatched++; $display("FAIL b2b_first_latency: got %0d, wanted 3", lat); end
        kick(0, 0, 1, 0, 4'd8, 32'h800, 16'h0200);
        wait_done(lat);
        compared++;
        if (lat != 2) begin mismatched++; $display("FAIL b2b_second_latency: got %0d, wanted 2", lat); end
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL b2b_pending: got %0d left, wanted 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_abort_and_ignore();
        int lat;
        for (int i = 0; i < 4; i++) begin
            regs[i] = 32'hC0 + 32'(i);
            sb.push_back(ev(1, 0, 0, 1, 32'h300 + 32'(4 * i), 4'(i), 32'hC0 + 32'(i)));
        end
        kick(0, 0, 1, 0, 4'd13, 32'h300, 16'h000F);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if ({rf_we, pc_we, mem_we, done, busy} !== 5'b0) begin
            mismatched++;
            $display("FAIL abort_strobes: got we=%b%b%b done=%b busy=%b, wanted all 0", rf_we, pc_we, mem_we, done, busy);
        end
        compared++;
        if (sb.size() != 2) begin mismatched++; $display("FAIL abort_progress: got %0d left, wanted 2", sb.size()); end
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_idle: got busy=%b, wanted 0", busy); end
        regs[5] = 32'h55; regs[6] = 32'h66; regs[7] = 32'h77;
        sb.push_back(ev(1, 0, 0, 1, 32'h900, 4'd5, 32'h55));
        sb.push_back(ev(1, 0, 0, 1, 32'h904, 4'd6, 32'h66));
        sb.push_back(ev(1, 0, 0, 1, 32'h908, 4'd7, 32'h77));
        kick(0, 0, 1, 0, 4'd13, 32'h900, 16'h00E0);
        @(negedge clk);
        is_load = 1'b1; wback = 1'b1; base = 32'hA00; reglist = 16'h0003; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        compared++;
        if (lat != 3) begin mismatched++; $display("FAIL ignore_latency: got %0d more cycles, wanted 3", lat); end
        compared++;
        if (sb.size() != 0) begin mismatched++; $display("FAIL ignore_pending: got %0d left, wanted 0", sb.size()); sb.delete(); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 32'(i) * 32'h100;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hF000_0000 + 32'(i);
        test_reset();
        test_stm_ia();
        test_ldm_db_wb();
        test_ldm_pc();
        test_ldm_rn_in_list();
        test_stm_da_rn_in_list();
        test_empty();
        test_back_to_back();
        test_abort_and_ignore();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
- Multi-cycle block-transfer sequencer for LDM/STM.
- Walks a 16-bit register list in ascending order, one register per cycle.
- Drives the register file's read port (STM) or write port (LDM), plus the data-memory port.
- Sits between the decoder/controller and the regfile/data memory; the controller stalls PC update while busy=1.

Parameters:
- DW, 32, data and address width.
- NREG, 16, register-list width (R0–R15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- is_load  in  1  1 = LDM, 0 = STM
- pre  in  1  P bit: 1 = before, 0 = after
- up  in  1  U bit: 1 = increment, 0 = decrement
- wback  in  1  W bit: base writeback
- rn  in  4  base register number
- base  in  DW  base register value
- reglist  in  NREG  register list, bit i = Ri
- rf_ra  out  4  regfile read address (STM)
- rf_rd  in  DW  regfile read data (combinational; R15 already supplied as PC+8 by the regfile)
- rf_we  out  1  regfile write enable
- rf_wa  out  4  regfile write address, never 15
- rf_wd  out  DW  regfile write data
- pc_we  out  1  load-to-PC strobe (LDM with R15 in list)
- pc_wd  out  DW  value for PC
- mem_addr  out  DW  word address
- mem_we  out  1  memory write enable
- mem_wd  out  DW  memory write data
- mem_rd  in  DW  memory read data (combinational)
- busy  out  1  high from the cycle after start until DONE completes
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: FSM=IDLE; all strobes (rf_we, pc_we, mem_we, done, busy) = 0; rf_ra, rf_wa = 0; addresses and data = 0. Reset mid-transfer aborts immediately; no further strobes.
- States:
  - IDLE: on start, latch is_load/wback/rn/reglist, compute N = popcount(reglist) and the start address; go to XFER. If reglist = 0, go to DONE with no transfers and no writeback.
  - XFER: handle the lowest set bit k of the remaining list; clear it; add 4 to the address. When the remaining list becomes 0, go to WB if wback, else DONE.
  - WB: rf_we=1, rf_wa=rn, rf_wd = final base; 1 cycle; then DONE.
  - DONE: done=1 for 1 cycle; then IDLE.
- Start address (mod 2^32): IA = base; IB = base+4; DA = base−4N+4; DB = base−4N. Addresses always ascend with register number.
- Final base: up ? base+4N : base−4N.
- STM transfer cycle: rf_ra=k, mem_addr=cur, mem_wd=rf_rd, mem_we=1.
- LDM transfer cycle: mem_addr=cur.
  - If k≠15: rf_we=1, rf_wa=k, rf_wd=mem_rd.
  - If k=15: pc_we=1, pc_wd=mem_rd, rf_we=0.
- LDM with wback and rn in reglist: WB is skipped; the loaded value wins.
- STM with rn in list: stores the original base value (WB has not yet occurred).
- start while busy: ignored.
- Latency from start to done = N + wback' + 1 cycles after the start edge, where wback' is the effective writeback.
- Strobes are combinational from state and registered context; each lasts exactly one cycle per transfer.

Decomposition:
- Shared include mcu_defs.vh holds:
  - FSM state encodings (IDLE, XFER, WB, DONE)
  - addressing-mode constants (IA/IB/DA/DB from {pre,up})
  - REG_PC = 4'd15
- One sub-module: lsb_pick, a combinational 16→4 lowest-set-bit encoder with a valid flag. Reuse it for the popcount-free walk.

Test Plan:
- STM IA: reglist=16'h0016 (R1,R2,R4), base=0x100, R1=0x11, R2=0x22, R4=0x44 -> writes 0x100=0x11, 0x104=0x22, 0x108=0x44; done at cycle 4; no regfile write.
- LDM DB with writeback: reglist=16'h00F0, base=0x200, rn=13, wback=1 -> reads 0x1F0..0x1FC into R4..R7; WB cycle writes R13=0x1F0; done at cycle 6.
- LDM including PC: reglist=16'h8001, base=0x40, mem[0x40]=0xA, mem[0x44]=0x80 -> R0=0xA; pc_we pulse with pc_wd=0x80; rf_we never asserted with rf_wa=15.
- LDM rn-in-list: rn=2, reglist=16'h0004, wback=1, mem=0xDEAD -> R2=0xDEAD; no WB cycle; done 2 cycles after start.
- Empty list: reglist=0 -> done 1 cycle after start; no mem_we, rf_we or pc_we.
- Reset/abort: assert rst_n=0 during the second transfer of a 4-register STM -> all strobes drop immediately; after release, IDLE with busy=0; a start pulse during busy is ignored.
